rmw_traffic_gen: RTL and testbench
==================================

# rmw_traffic_gen

Parametrised random read-modify-write traffic generator for the memory-port handshake (`req`/`wr`/`rdy`). It succeeds the fixed 64-bit increment generator. Data and address widths are parameters, and the increment step, operation count and seed are programmable. An optional read-back check verifies every write. The block sits between the system controller and a memory model or arbiter, driving one memory port.

## Interface
- `DATA_W`, 64: data width of `din`/`dout`/`step`
- `ADDR_W`, 64: width of `addr` and `range`
- `CNT_W`, 32: width of `num_ops`, `op_count`, `err_count`
- `clk` in 1: clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a run; sampled only in IDLE or DONE
- `seed` in 32: LFSR seed, loaded on `start`; a value of 0 is replaced by 1
- `range` in ADDR_W: address mask, so `addr = zero-extended LFSR & range`
- `step` in DATA_W: value added to the read data
- `num_ops` in CNT_W: number of RMW operations per run
- `addr` out ADDR_W: transaction address
- `dout` out DATA_W: write data
- `din` in DATA_W: read data, valid in the cycle `rdy`=1
- `req` out 1: transaction request
- `wr` out 1: 1 for a write, 0 for a read; valid while `req`=1
- `rdy` in 1: one-cycle completion pulse; ignored while `req`=0
- `busy` out 1: high from GEN until DONE
- `done` out 1: run complete; held until next `start` or `rst`
- `op_count` out CNT_W: completed operations this run
- `err_count` out CNT_W: read-back mismatches, saturating

## Operation
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 0x8020_0003).
  - Shifts right once per GEN cycle.
  - The `addr` for an operation is the LFSR value after that shift.
- States, in order: IDLE, GEN, RD, RW_GAP, WR, VR_GAP, VR, DONE.
- IDLE or DONE with `start`=1:
  - load the LFSR and clear `op_count`, `err_count` and `done`;
  - go to GEN, or straight to DONE if `num_ops`=0.
- GEN: advance the LFSR, latch `addr`, then go to RD. `req`=0.
- RD: `req`=1, `wr`=0. On `rdy`, capture `din` into `rdata` and go to RW_GAP.
- RW_GAP: `req`=0 for one cycle, `dout = rdata + step` (mod 2^DATA_W), then go to WR.
- WR: `req`=1, `wr`=1, `addr` and `dout` stable. On `rdy`, go to VR_GAP if the check is compiled in, otherwise go to the op-complete step.
- VR_GAP: `req`=0 for one cycle, then go to VR.
- VR: `req`=1, `wr`=0.
  - On `rdy`, compare `din` with `dout`.
  - On mismatch, increment `err_count`, saturating at all-ones.
  - Then go to the op-complete step.
- Op complete:
  - increment `op_count`;
  - if it then equals `num_ops`, go to DONE (`done`=1, `busy`=0);
  - otherwise go to GEN.
- `addr`, `wr` and `dout` hold constant while `req`=1.
- `req` never stays high in the cycle after `rdy`.
- `start` while `busy` is ignored.

## Timing
- Reset values: `req`=0, `wr`=0, `addr`=0, `dout`=0, `busy`=0, `done`=0, `op_count`=0, `err_count`=0. LFSR = 1, state = IDLE.
- Reset mid-transaction:
  - `req` drops in the cycle after `rst` is sampled;
  - any in-flight `rdy` is ignored and there is no write-back.
- `start` sampled at edge N: GEN in cycle N+1, first `req` in cycle N+2.
- Latency is measured from `req` rise to `rdy`, and can be zero extra cycles (`rdy` in the first RD cycle).
- Minimum operation length:
  - 4 cycles without the check (GEN, RD, RW_GAP, WR);
  - 6 cycles with the check.
- `done` and `busy` both change in the cycle after the final `rdy`.
- `rdy` during GEN, a gap state, IDLE or DONE has no effect.

## Configuration
- `RMW_READBACK_EN`
  - Defined: the VR_GAP and VR states exist, and every write is followed by a verify read that updates `err_count`.
  - Undefined: WR goes directly to the op-complete step, and `err_count` is tied to 0.

## Test plan
- Reset and one operation:
  - Setup: `rst` for 3 cycles, then `seed`=1, `range`=0x1FFF, `step`=1, `num_ops`=1, `start`. Bench returns `din`=0x10 with `rdy` one cycle after `req`.
  - Required: `addr` = 0x0003 (LFSR 0x80200003 masked), read, then write `dout`=0x11 to the same `addr`; `done`=1 and `op_count`=1.
- Wrap-around:
  - Setup: `DATA_W`=64, `din`=0xFFFF_FFFF_FFFF_FFFF, `step`=2.
  - Required: `dout`=0x1 and no error.
- Back-to-back `rdy`:
  - Setup: bench asserts `rdy` in every cycle where `req`=1, with `num_ops`=3.
  - Required: exactly 3 read and 3 write handshakes, `req` low between each pair, 12 cycles total without the check.
- Read-back error (macro defined):
  - Setup: bench returns the written value +1 on the verify read, with `num_ops`=4.
  - Required: `err_count`=4 and `op_count`=4.
- Zero operations: `num_ops`=0 with `start`. Required: `done`=1 the next cycle and `req` never asserted.
- Reset mid-write:
  - Setup: `rst` while in WR with `rdy` held low.
  - Required: next cycle `req`=0 and all outputs at reset values; a later `rdy`=1 is ignored.

Source files
------------

// File: rtl/rmw_traffic_gen.sv
// Random read-modify-write generator driving one req/wr/rdy memory port.
// Define RMW_READBACK_EN to add a verify read after every write.
module rmw_traffic_gen #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [ADDR_W-1:0] range,
  input  logic [DATA_W-1:0] step,
  input  logic [CNT_W-1:0]  num_ops,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] dout,
  input  logic [DATA_W-1:0] din,
  output logic              req,
  output logic              wr,
  input  logic              rdy,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  op_count,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    RD,
    RW_GAP,
    WR,
    VR_GAP,
    VR,
    DONE
  } state_t;

  localparam logic [31:0] POLY = 32'h8020_0003;

  state_t            state_q, state_d;
  logic [31:0]       lfsr_q, lfsr_nx;
  logic [ADDR_W-1:0] addr_q, addr_gen;
  logic [DATA_W-1:0] dout_q, rdata_q;
  logic [CNT_W-1:0]  cnt_q, ops_q, cnt_inc;
  logic              start_ok, op_fin;

  assign lfsr_nx  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign start_ok = start && (state_q == IDLE || state_q == DONE);

  generate
    if (ADDR_W > 32) begin : g_wide
      assign addr_gen = {{(ADDR_W-32){1'b0}}, lfsr_nx} & range;
    end else begin : g_narrow
      assign addr_gen = lfsr_nx[ADDR_W-1:0] & range;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    op_fin  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start)
          state_d = (num_ops == '0) ? DONE : GEN;
      end
      GEN:    state_d = RD;
      RD:     if (rdy) state_d = RW_GAP;
      RW_GAP: state_d = WR;
      WR: begin
        if (rdy) begin
`ifdef RMW_READBACK_EN
          state_d = VR_GAP;
`else
          op_fin  = 1'b1;
`endif
        end
      end
      VR_GAP: state_d = VR;
      VR:     if (rdy) op_fin = 1'b1;
      default: state_d = IDLE;
    endcase
    if (op_fin)
      state_d = (cnt_inc == ops_q) ? DONE : GEN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= 32'h1;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      ops_q   <= '0;
    end else begin
      if (start_ok) begin
        lfsr_q <= (seed == 32'h0) ? 32'h1 : seed;
        cnt_q  <= '0;
        ops_q  <= num_ops;
      end
      if (state_q == GEN) begin
        lfsr_q <= lfsr_nx;
        addr_q <= addr_gen;
      end
      if (state_q == RD && rdy)
        rdata_q <= din;
      if (state_q == RW_GAP)
        dout_q <= rdata_q + step;
      if (op_fin)
        cnt_q <= cnt_inc;
    end
  end

`ifdef RMW_READBACK_EN
  logic [CNT_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else if (start_ok) begin
      err_q <= '0;
    end else if (state_q == VR && rdy && din != dout_q) begin
      if (err_q != '1)
        err_q <= err_q + CNT_W'(1);
    end
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

  assign req      = (state_q == RD) || (state_q == WR) || (state_q == VR);
  assign wr       = (state_q == WR);
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign addr     = addr_q;
  assign dout     = dout_q;
  assign op_count = cnt_q;

endmodule

// File: tb/tb_rmw_traffic_gen.sv
// Scoreboard bench for rmw_traffic_gen: model queues expected port
// transactions, a memory responder answers, a monitor compares.
module tb_rmw_traffic_gen;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int CW = 32;
`ifdef RMW_READBACK_EN
  localparam int VRF = 1;
`else
  localparam int VRF = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [31:0]   seed = '0;
  logic [AW-1:0] range = '0;
  logic [DW-1:0] step = '0;
  logic [CW-1:0] num_ops = '0;
  logic [DW-1:0] din = '0;
  logic          rdy = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] dout;
  logic          req, wr, busy, done;
  logic [CW-1:0] op_count, err_count;

  rmw_traffic_gen #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed),
    .range(range), .step(step), .num_ops(num_ops),
    .addr(addr), .dout(dout), .din(din), .req(req), .wr(wr),
    .rdy(rdy), .busy(busy), .done(done),
    .op_count(op_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [63:0] a;
    logic [63:0] d;
  } txn_t;

  txn_t        expq[$];
  logic [63:0] mmem[logic [63:0]];
  logic [63:0] rmem[logic [63:0]];
  int          checks = 0;
  int          passed = 0;

  bit          const_mode = 1'b0;
  logic [63:0] const_din = '0;
  logic [63:0] init_base = '0;
  bit          auto_en = 1'b1;
  bit          hold_wr = 1'b0;
  bit          manual_rdy = 1'b0;
  int          lat_lo = 0, lat_hi = 0, lat = 0, wcnt = 0;
  int          corrupt_mode = 0;
  int          exp_err = 0;
  bit          verify_pend = 1'b0;
  bit          req_seen = 1'b0;
  int          n_rd = 0, n_wr = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [63:0] init_val(input logic [63:0] a);
    if (const_mode) return const_din;
    return init_base ^ (a * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  // memory responder: random latency, optional corrupted verify data
  initial begin
    bit cor;
    forever begin
      @(posedge clk); #1;
      if (!auto_en) begin
        rdy = manual_rdy;
      end else begin
        rdy = 1'b0;
        if (req && !rst && !(wr && hold_wr)) begin
          if (wcnt >= lat) begin
            rdy  = 1'b1;
            wcnt = 0;
            lat  = $urandom_range(lat_hi, lat_lo);
            if (wr) begin
              rmem[addr] = dout;
              verify_pend = (VRF == 1);
            end else if (verify_pend) begin
              verify_pend = 1'b0;
              cor = (corrupt_mode == 1) ||
                    (corrupt_mode == 2 && $urandom_range(1, 0) == 1);
              din = rmem[addr] + (cor ? 64'd1 : 64'd0);
              if (cor) exp_err++;
            end else begin
              din = rmem.exists(addr) ? rmem[addr] : init_val(addr);
            end
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // monitor: pops the scoreboard on every handshake
  initial begin
    bit          p_hs, p_req, p_wr;
    logic [63:0] p_a, p_d;
    txn_t        t;
    p_hs = 0; p_req = 0; p_wr = 0; p_a = '0; p_d = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (p_hs) begin
          chk("req_after_rdy", 64'(req), 64'd0);
        end else if (p_req && req) begin
          chk("addr_stable", addr, p_a);
          chk("wr_stable", 64'(wr), 64'(p_wr));
          chk("dout_stable", dout, p_d);
        end
        if (req) req_seen = 1'b1;
        if (req && rdy) begin
          if (expq.size() == 0) begin
            chk("unexpected_txn", 64'd1, 64'd0);
          end else begin
            t = expq.pop_front();
            chk("txn_wr", 64'(wr), 64'(t.w));
            chk("txn_addr", addr, t.a);
            if (t.w) chk("txn_dout", dout, t.d);
          end
          if (wr) n_wr++;
          else    n_rd++;
        end
      end
      p_hs  = req && rdy && !rst;
      p_req = req && !rst;
      p_wr  = wr;
      p_a   = addr;
      p_d   = dout;
    end
  end

  task automatic prepare(input logic [31:0] sd, input logic [63:0] rg,
                         input logic [63:0] st, input int n,
                         input int llo, input int lhi, input int cm);
    logic [31:0] l;
    logic [63:0] a, v;
    txn_t        t;
    seed = sd; range = rg; step = st; num_ops = CW'(n);
    lat_lo = llo; lat_hi = lhi; lat = $urandom_range(lhi, llo);
    wcnt = 0; corrupt_mode = cm; exp_err = 0; verify_pend = 1'b0;
    rmem.delete(); mmem.delete(); expq.delete();
    req_seen = 1'b0; n_rd = 0; n_wr = 0;
    l = (sd == 32'h0) ? 32'h1 : sd;
    for (int i = 0; i < n; i++) begin
      l = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0);
      a = {32'h0, l} & rg;
      v = mmem.exists(a) ? mmem[a] : init_val(a);
      v = v + st;
      mmem[a] = v;
      t.w = 1'b0; t.a = a; t.d = '0; expq.push_back(t);
      t.w = 1'b1; t.d = v;           expq.push_back(t);
      if (VRF == 1) begin
        t.w = 1'b0; t.d = '0; expq.push_back(t);
      end
    end
  endtask

  task automatic run(input logic [31:0] sd, input logic [63:0] rg,
                     input logic [63:0] st, input int n,
                     input int llo, input int lhi, input int cm,
                     output int cyc);
    prepare(sd, rg, st, n, llo, lhi, cm);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (n > 0) chk("busy_start", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_end", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("op_count", 64'(op_count), 64'(n));
    chk("err_count", 64'(err_count), 64'(exp_err));
    chk("queue_empty", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_dout", dout, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_opcnt", 64'(op_count), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    const_mode = 1'b1;
    const_din  = 64'h10;
    run(32'h1, 64'h1FFF, 64'd1, 1, 1, 1, 0, cyc);
    chk("one_addr", addr, 64'h3);
    chk("one_dout", dout, 64'h11);
    chk("one_nwr", 64'(n_wr), 64'd1);
    chk("one_nrd", 64'(n_rd), 64'(1 + VRF));

    const_din = '1;
    run($urandom, 64'hFFFF, 64'd2, 1, 0, 2, 0, cyc);
    chk("wrap_dout", dout, 64'h1);
    chk("wrap_err", 64'(err_count), 64'd0);

    const_mode = 1'b0;
    init_base  = {$urandom, $urandom};
    run($urandom, 64'hFF, {$urandom, $urandom}, 3, 0, 0, 0, cyc);
    chk("b2b_cycles", 64'(cyc), 64'(12 + 6 * VRF));
    chk("b2b_nwr", 64'(n_wr), 64'd3);
    chk("b2b_nrd", 64'(n_rd), 64'(3 + 3 * VRF));

`ifdef RMW_READBACK_EN
    run($urandom, 64'h3F, 64'd5, 4, 0, 2, 1, cyc);
    chk("rb_err", 64'(err_count), 64'd4);
    chk("rb_ops", 64'(op_count), 64'd4);
`endif

    run($urandom, 64'hFF, 64'd1, 0, 0, 0, 0, cyc);
    chk("zero_cycles", 64'(cyc), 64'd0);
    chk("zero_req", 64'(req_seen), 64'd0);

    for (int k = 0; k < 8; k++) begin
      init_base = {$urandom, $urandom};
      run((k == 0) ? 32'h0 : $urandom,
          64'($urandom_range(32'hFFFF, 0)),
          {$urandom, $urandom},
          $urandom_range(20, 1), 0, 3, 2, cyc);
    end

    hold_wr = 1'b1;
    prepare($urandom, 64'hFF, 64'd7, 1, 0, 1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(req && wr) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reach_wr", 64'(req && wr), 64'd1);
    auto_en = 1'b0;
    manual_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_req", 64'(req), 64'd0);
    chk("mid_addr", addr, 64'd0);
    chk("mid_dout", dout, 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_opcnt", 64'(op_count), 64'd0);
    rst = 1'b0;
    expq.delete();
    manual_rdy = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("late_rdy_req", 64'(req), 64'd0);
      chk("late_rdy_busy", 64'(busy), 64'd0);
      chk("late_rdy_done", 64'(done), 64'd0);
    end
    manual_rdy = 1'b0;
    auto_en = 1'b1;
    hold_wr = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
